// File: rtl/tdma_rx_parser.sv
// Queues RX frame buffer addresses, fetches each frame's 16-byte TDMA payload over
// the IPIC single-read port and hands decoded PING / ACK_PING events to the control block.
module tdma_rx_parser #(
    parameter int          ADDR_WIDTH     = 32,
    parameter int          DATA_WIDTH     = 32,
    parameter int          FIFO_DEPTH     = 4,
    parameter int unsigned PAYLOAD_OFFSET = 32'h20,
    parameter int          TIMEOUT_CYCLES = 1024
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  rx_addr_valid,
    input  logic [ADDR_WIDTH-1:0] rx_addr,
    input  logic                  consumer_idle,
    output logic                  ipic_start,
    output logic [2:0]            ipic_type,
    output logic [ADDR_WIDTH-1:0] read_addr,
    input  logic                  ipic_ack,
    input  logic                  ipic_done,
    input  logic [DATA_WIDTH-1:0] single_read_data,
    output logic                  recv_ping,
    output logic                  recv_ack_ping,
    output logic [31:0]           recv_seq,
    output logic [31:0]           recv_sec,
    output logic [31:0]           recv_counter2,
    output logic [15:0]           drop_cnt,
    output logic [15:0]           ovf_cnt,
    output logic [15:0]           timeout_cnt
);

    localparam int                 PTR_W      = $clog2(FIFO_DEPTH);
    localparam int                 TIMER_W    = $clog2(TIMEOUT_CYCLES);
    localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(TIMEOUT_CYCLES - 1);
    localparam logic [PTR_W:0]     FIFO_CAP   = (PTR_W + 1)'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT_ACK,
        WAIT_DONE,
        CHECK,
        DELIVER
    } state_t;

    state_t state, state_next;

    logic [ADDR_WIDTH-1:0] fifo_mem [FIFO_DEPTH];
    logic [PTR_W:0]        wr_ptr, rd_ptr;
    logic                  fifo_empty, fifo_full, pop, push;

    logic [ADDR_WIDTH-1:0] base;
    logic [1:0]            idx;
    logic [TIMER_W-1:0]    timer;
    logic [5:0]            flag;
    logic                  flag_ok;
    logic [DATA_WIDTH-1:0] seq_w, sec_w, cnt_w;
    logic                  pend_ping, pend_ack;

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    assign fifo_empty = (wr_ptr == rd_ptr);
    assign fifo_full  = ((wr_ptr - rd_ptr) == FIFO_CAP);
    assign pop        = (state == IDLE) && !fifo_empty;
    // A full queue still takes the new address when the head leaves in the same cycle.
    assign push       = rx_addr_valid && (!fifo_full || pop);
    assign flag_ok    = (flag == 6'd1) || (flag == 6'd2);
    assign ipic_type  = 3'd2;

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr[PTR_W-1:0]] <= rx_addr;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:      if (!fifo_empty) state_next = ISSUE;
            ISSUE:     state_next = WAIT_ACK;
            WAIT_ACK:  if (ipic_ack) state_next = WAIT_DONE;
            WAIT_DONE: begin
                if (ipic_done) begin
                    if (idx == 2'd0)      state_next = CHECK;
                    else if (idx != 2'd3) state_next = ISSUE;
                    else                  state_next = DELIVER;
                end else if (timer == TIMER_LAST) begin
                    state_next = IDLE;
                end
            end
            CHECK:     state_next = flag_ok ? ISSUE : IDLE;
            DELIVER:   if (consumer_idle) state_next = IDLE;
            default:   state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            base          <= '0;
            idx           <= '0;
            timer         <= '0;
            flag          <= '0;
            seq_w         <= '0;
            sec_w         <= '0;
            cnt_w         <= '0;
            pend_ping     <= 1'b0;
            pend_ack      <= 1'b0;
            ipic_start    <= 1'b0;
            read_addr     <= '0;
            recv_ping     <= 1'b0;
            recv_ack_ping <= 1'b0;
            recv_seq      <= '0;
            recv_sec      <= '0;
            recv_counter2 <= '0;
            drop_cnt      <= '0;
            ovf_cnt       <= '0;
            timeout_cnt   <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            if (rx_addr_valid && !push) ovf_cnt <= sat_inc(ovf_cnt);

            // Pulses trail the data registers by one cycle so data is settled first.
            recv_ping     <= pend_ping;
            recv_ack_ping <= pend_ack;
            pend_ping     <= 1'b0;
            pend_ack      <= 1'b0;

            case (state)
                IDLE: begin
                    if (!fifo_empty) begin
                        base <= fifo_mem[rd_ptr[PTR_W-1:0]];
                        idx  <= 2'd0;
                    end
                end
                ISSUE: begin
                    ipic_start <= 1'b1;
                    read_addr  <= base + ADDR_WIDTH'(PAYLOAD_OFFSET) + ADDR_WIDTH'({idx, 2'b00});
                end
                WAIT_ACK: begin
                    if (ipic_ack) begin
                        ipic_start <= 1'b0;
                        timer      <= '0;
                    end
                end
                WAIT_DONE: begin
                    if (ipic_done) begin
                        case (idx)
                            2'd0:    flag  <= single_read_data[5:0];
                            2'd1:    seq_w <= single_read_data;
                            2'd2:    sec_w <= single_read_data;
                            default: cnt_w <= single_read_data;
                        endcase
                        if (idx != 2'd0 && idx != 2'd3) idx <= idx + 2'd1;
                    end else if (timer == TIMER_LAST) begin
                        timeout_cnt <= sat_inc(timeout_cnt);
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                CHECK: begin
                    if (flag_ok) idx <= 2'd1;
                    else         drop_cnt <= sat_inc(drop_cnt);
                end
                DELIVER: begin
                    if (consumer_idle) begin
                        recv_seq      <= 32'(seq_w);
                        recv_sec      <= 32'(sec_w);
                        recv_counter2 <= 32'(cnt_w);
                        pend_ping     <= (flag == 6'd1);
                        pend_ack      <= (flag == 6'd2);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_tdma_rx_parser.sv
// Directed bench for tdma_rx_parser: IPIC responder backed by a payload memory,
// frame-level expectation queues and a per-cycle compare process.
`timescale 1ns/1ps
module tb_tdma_rx_parser;

    localparam int F_NORMAL  = 0;
    localparam int F_LOST    = 1;
    localparam int F_TIMEOUT = 2;
    localparam int F_RESET   = 3;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        rx_addr_valid = 1'b0;
    logic [31:0] rx_addr = '0;
    logic        consumer_idle = 1'b1;
    logic        ipic_start;
    logic [2:0]  ipic_type;
    logic [31:0] read_addr;
    logic        ipic_ack = 1'b0;
    logic        ipic_done = 1'b0;
    logic [31:0] single_read_data = '0;
    logic        recv_ping, recv_ack_ping;
    logic [31:0] recv_seq, recv_sec, recv_counter2;
    logic [15:0] drop_cnt, ovf_cnt, timeout_cnt;

    tdma_rx_parser dut (
        .clk              (clk),
        .reset            (reset),
        .rx_addr_valid    (rx_addr_valid),
        .rx_addr          (rx_addr),
        .consumer_idle    (consumer_idle),
        .ipic_start       (ipic_start),
        .ipic_type        (ipic_type),
        .read_addr        (read_addr),
        .ipic_ack         (ipic_ack),
        .ipic_done        (ipic_done),
        .single_read_data (single_read_data),
        .recv_ping        (recv_ping),
        .recv_ack_ping    (recv_ack_ping),
        .recv_seq         (recv_seq),
        .recv_sec         (recv_sec),
        .recv_counter2    (recv_counter2),
        .drop_cnt         (drop_cnt),
        .ovf_cnt          (ovf_cnt),
        .timeout_cnt      (timeout_cnt)
    );

    // clock / reset
    always #5 clk = ~clk;

    typedef struct packed {
        logic [1:0]  kind;
        logic [31:0] seq;
        logic [31:0] sec;
        logic [31:0] cnt2;
    } ev_t;

    ev_t         exp_ev_q[$];
    logic [31:0] exp_addr_q[$];
    logic [31:0] rd_log[$];
    logic [31:0] mem [logic [31:0]];

    int checks = 0;
    int failures = 0;
    int n_pulses = 0;

    logic        ack_hold = 1'b0;
    logic        release_done = 1'b0;
    logic        holding = 1'b0;
    logic [31:0] skip_done_addr = 32'hFFFF_FFFF;
    logic [31:0] hold_done_addr = 32'hFFFF_FFFF;
    logic        ci_d1 = 1'b0, ci_d2 = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Frame model: decides from the payload alone which reads and which event must appear.
    task automatic load_frame(input logic [31:0] base, input logic [31:0] w0, input logic [31:0] w1,
                              input logic [31:0] w2, input logic [31:0] w3, input int fate);
        logic [31:0] a;
        logic [5:0]  flag;
        int          nreads;
        ev_t         ev;
        a = base + 32'h20;
        mem[a]      = w0;
        mem[a + 4]  = w1;
        mem[a + 8]  = w2;
        mem[a + 12] = w3;
        flag   = w0[5:0];
        nreads = (flag == 6'd1 || flag == 6'd2) ? 4 : 1;
        if (fate == F_LOST)    nreads = 0;
        if (fate == F_TIMEOUT) nreads = 1;
        if (fate == F_RESET)   nreads = 3;
        for (int i = 0; i < nreads; i++) exp_addr_q.push_back(a + 32'(4 * i));
        if (fate == F_NORMAL && nreads == 4) begin
            ev.kind = flag[1:0];
            ev.seq  = w1;
            ev.sec  = w2;
            ev.cnt2 = w3;
            exp_ev_q.push_back(ev);
        end
    endtask

    task automatic push_addr(input logic [31:0] a);
        rx_addr       = a;
        rx_addr_valid = 1'b1;
        @(posedge clk); #1;
        rx_addr_valid = 1'b0;
    endtask

    task automatic wait_drain(input string name, input int budget);
        int n;
        n = 0;
        while ((exp_ev_q.size() != 0 || exp_addr_q.size() != 0) && n < budget) begin
            @(posedge clk); #1;
            n++;
        end
        check(name, 64'(n < budget), 64'd1);
        repeat (4) @(posedge clk);
        #1;
    endtask

    // IPIC responder: ack one cycle after the request, done one cycle after the ack.
    initial begin
        logic [31:0] cur;
        forever begin
            @(posedge clk); #1;
            if (ipic_start === 1'b1 && !ack_hold) begin
                cur = read_addr;
                rd_log.push_back(cur);
                if (exp_addr_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_read: got %0h expected none", cur);
                end else begin
                    check("read_addr", 64'(cur), 64'(exp_addr_q.pop_front()));
                end
                ipic_ack = 1'b1;
                @(posedge clk); #1;
                ipic_ack = 1'b0;
                if (cur != skip_done_addr) begin
                    if (cur == hold_done_addr) begin
                        holding = 1'b1;
                        wait (release_done);
                        holding = 1'b0;
                    end
                    single_read_data = mem.exists(cur) ? mem[cur] : 32'h0;
                    ipic_done = 1'b1;
                    @(posedge clk); #1;
                    ipic_done = 1'b0;
                end
            end
        end
    end

    always @(posedge clk) begin
        ci_d1 <= consumer_idle;
        ci_d2 <= ci_d1;
    end

    // Scoreboard compare: every pulse must match the oldest expected event.
    initial begin
        ev_t ev;
        forever begin
            @(negedge clk);
            if (!reset && (recv_ping === 1'b1 || recv_ack_ping === 1'b1)) begin
                n_pulses++;
                check("pulse_exclusive", 64'(recv_ping & recv_ack_ping), 64'd0);
                check("pulse_consumer_idle", 64'(ci_d2), 64'd1);
                if (exp_ev_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_pulse: got ping=%0b ack=%0b expected none", recv_ping, recv_ack_ping);
                end else begin
                    ev = exp_ev_q.pop_front();
                    check("pulse_kind", 64'({recv_ack_ping, recv_ping}), 64'(ev.kind));
                    check("recv_seq", 64'(recv_seq), 64'(ev.seq));
                    check("recv_sec", 64'(recv_sec), 64'(ev.sec));
                    check("recv_counter2", 64'(recv_counter2), 64'(ev.cnt2));
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int p0, n, saw;
        logic [31:0] ob [7];

        repeat (3) @(posedge clk);
        #1;
        check("rst_ipic_start", 64'(ipic_start), 64'd0);
        check("rst_ipic_type", 64'(ipic_type), 64'd2);
        check("rst_read_addr", 64'(read_addr), 64'd0);
        check("rst_pulses", 64'({recv_ping, recv_ack_ping}), 64'd0);
        check("rst_data", 64'({recv_seq, recv_sec} | 64'(recv_counter2)), 64'd0);
        check("rst_counters", 64'({drop_cnt, ovf_cnt, timeout_cnt}), 64'd0);
        reset = 1'b0;
        @(posedge clk); #1;

        // PING frame
        rd_log.delete();
        load_frame(32'h1000_0000, 32'h0000_0001, 32'd7, 32'h5A5A_0001, 32'h000F_4000, F_NORMAL);
        push_addr(32'h1000_0000);
        wait_drain("t1_drain", 200);
        check("t1_nreads", 64'(rd_log.size()), 64'd4);
        check("t1_addr0", 64'(rd_log[0]), 64'h1000_0020);
        check("t1_addr1", 64'(rd_log[1]), 64'h1000_0024);
        check("t1_addr2", 64'(rd_log[2]), 64'h1000_0028);
        check("t1_addr3", 64'(rd_log[3]), 64'h1000_002C);
        check("t1_pulses", 64'(n_pulses), 64'd1);
        check("t1_seq_held", 64'(recv_seq), 64'd7);
        check("t1_sec_held", 64'(recv_sec), 64'h5A5A_0001);
        check("t1_cnt2_held", 64'(recv_counter2), 64'h000F_4000);

        // ACK_PING frame with consumer busy
        consumer_idle = 1'b0;
        p0 = n_pulses;
        load_frame(32'h1100_0000, 32'h0000_0002, 32'd99, 32'h0000_1234, 32'h00AB_CDEF, F_NORMAL);
        push_addr(32'h1100_0000);
        repeat (50) @(posedge clk);
        #1;
        check("t2_no_pulse_busy", 64'(n_pulses - p0), 64'd0);
        check("t2_reads_done", 64'(exp_addr_q.size()), 64'd0);
        consumer_idle = 1'b1;
        n = 0;
        while (recv_ack_ping !== 1'b1 && n < 10) begin
            @(posedge clk); #1;
            n++;
        end
        check("t2_pulse_delay", 64'(n), 64'd2);
        check("t2_seq", 64'(recv_seq), 64'd99);
        check("t2_cnt2", 64'(recv_counter2), 64'h00AB_CDEF);
        wait_drain("t2_drain", 50);

        // unknown flag
        rd_log.delete();
        p0 = n_pulses;
        load_frame(32'h1200_0000, 32'hABCD_00FF, 32'd1, 32'd2, 32'd3, F_NORMAL);
        push_addr(32'h1200_0000);
        wait_drain("t3_drain", 100);
        check("t3_nreads", 64'(rd_log.size()), 64'd1);
        check("t3_drop_cnt", 64'(drop_cnt), 64'd1);
        check("t3_no_pulse", 64'(n_pulses - p0), 64'd0);

        // overflow while stalled in WAIT_ACK
        rd_log.delete();
        p0 = n_pulses;
        ack_hold = 1'b1;
        ob[0] = 32'h2000_0000;
        ob[1] = 32'hFFFF_FFF0;
        ob[2] = 32'h3000_0100;
        ob[3] = 32'h3000_0200;
        ob[4] = 32'h3000_0300;
        ob[5] = 32'h3000_0400;
        ob[6] = 32'h3000_0500;
        for (int i = 0; i < 7; i++) begin
            load_frame(ob[i], (i == 2) ? 32'hFFFF_FFC1 : 32'(1 + (i % 2)), 32'(100 + i),
                       32'h5A00_0000 + 32'(i), 32'h000F_0000 + 32'(i), (i < 5) ? F_NORMAL : F_LOST);
        end
        push_addr(ob[0]);
        n = 0;
        while (ipic_start !== 1'b1 && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        check("t4_stalled", 64'(ipic_start), 64'd1);
        for (int i = 1; i < 7; i++) begin
            rx_addr       = ob[i];
            rx_addr_valid = 1'b1;
            @(posedge clk); #1;
        end
        rx_addr_valid = 1'b0;
        check("t4_ovf_cnt", 64'(ovf_cnt), 64'd2);
        ack_hold = 1'b0;
        wait_drain("t4_drain", 500);
        check("t4_pulses", 64'(n_pulses - p0), 64'd5);
        check("t4_wrap_addr0", 64'(rd_log[4]), 64'h0000_0010);
        check("t4_wrap_addr3", 64'(rd_log[7]), 64'h0000_001C);

        // read timeout, then next frame
        p0 = n_pulses;
        skip_done_addr = 32'h4000_0020;
        load_frame(32'h4000_0000, 32'h0000_0001, 32'd5, 32'd6, 32'd7, F_TIMEOUT);
        load_frame(32'h4000_1000, 32'h0000_0002, 32'd55, 32'd66, 32'd77, F_NORMAL);
        push_addr(32'h4000_0000);
        push_addr(32'h4000_1000);
        wait_drain("t5_drain", 1500);
        skip_done_addr = 32'hFFFF_FFFF;
        check("t5_timeout_cnt", 64'(timeout_cnt), 64'd1);
        check("t5_pulses", 64'(n_pulses - p0), 64'd1);
        check("counters_before_reset", 64'({drop_cnt, ovf_cnt, timeout_cnt}), 64'h0001_0002_0001);

        // reset during WAIT_DONE of word 2, stale done afterwards
        p0 = n_pulses;
        hold_done_addr = 32'h5000_0028;
        load_frame(32'h5000_0000, 32'h0000_0001, 32'd11, 32'd12, 32'd13, F_RESET);
        load_frame(32'h5000_1000, 32'h0000_0002, 32'd21, 32'd22, 32'd23, F_LOST);
        push_addr(32'h5000_0000);
        push_addr(32'h5000_1000);
        n = 0;
        while (!holding && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        check("t6_holding", 64'(holding), 64'd1);
        reset = 1'b1;
        @(posedge clk); #1;
        check("t6_rst_ipic_start", 64'(ipic_start), 64'd0);
        check("t6_rst_ipic_type", 64'(ipic_type), 64'd2);
        check("t6_rst_data", 64'({recv_seq, recv_sec} | 64'(recv_counter2) | 64'(read_addr)), 64'd0);
        check("t6_rst_counters", 64'({drop_cnt, ovf_cnt, timeout_cnt}), 64'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        release_done = 1'b1;
        saw = 0;
        for (int i = 0; i < 30; i++) begin
            @(posedge clk); #1;
            if (ipic_start !== 1'b0 || recv_ping !== 1'b0 || recv_ack_ping !== 1'b0) saw++;
        end
        hold_done_addr = 32'hFFFF_FFFF;
        check("t6_quiet_after_reset", 64'(saw), 64'd0);
        check("t6_no_pulse", 64'(n_pulses - p0), 64'd0);
        check("t6_seq_zero", 64'(recv_seq), 64'd0);

        // recovery frame
        load_frame(32'h6000_0000, 32'h0000_0002, 32'd31, 32'd32, 32'h0012_3456, F_NORMAL);
        push_addr(32'h6000_0000);
        wait_drain("t7_drain", 200);
        check("t7_cnt2", 64'(recv_counter2), 64'h0012_3456);
        check("t7_pulses", 64'(n_pulses - p0), 64'd1);

        check("final_exp_events", 64'(exp_ev_q.size()), 64'd0);
        check("final_exp_reads", 64'(exp_addr_q.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/tdma_rx_parser.md
Name: tdma_rx_parser

Overview:
- Upstream stage of the TDMA control/ping engine. Takes addresses of received frame buffers from the RX descriptor logic and queues them.
- For each frame it fetches the 16-byte TDMA payload (flag, seq, utc_sec, gps_counter2) over the IPIC single-read interface.
- It presents a decoded PING or ACK_PING event to the control block's recv_* inputs, and only while that block reports idle.

Parameters:
- ADDR_WIDTH, 32, IPIC address width
- DATA_WIDTH, 32, IPIC data width
- FIFO_DEPTH, 4, pending RX buffer address queue depth (power of 2)
- PAYLOAD_OFFSET, 32'h20, byte offset of payload in buffer (30 B MAC header + 2 B pad)
- TIMEOUT_CYCLES, 1024, max cycles from ack to ipic_done before abort

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- rx_addr_valid  in  1  one-cycle strobe: new RX buffer address
- rx_addr  in  ADDR_WIDTH  RX buffer base address
- consumer_idle  in  1  high when downstream control FSM can accept an event
- ipic_start  out  1  IPIC request
- ipic_type  out  3  request type; always 2 (SINGLE_RD)
- read_addr  out  ADDR_WIDTH  IPIC read address
- ipic_ack  in  1  request accepted
- ipic_done  in  1  read complete; single_read_data valid this cycle
- single_read_data  in  DATA_WIDTH  read data
- recv_ping  out  1  one-cycle pulse: PING decoded
- recv_ack_ping  out  1  one-cycle pulse: ACK_PING decoded
- recv_seq  out  32  decoded seq, held until next event
- recv_sec  out  32  decoded utc_sec, held
- recv_counter2  out  32  decoded gps_counter2, held
- drop_cnt  out  16  frames with unknown flag, saturating
- ovf_cnt  out  16  addresses lost to full FIFO, saturating
- timeout_cnt  out  16  aborted reads, saturating

Behaviour:
- Reset (sync, active-high, any cycle incl. mid-transaction): all outputs 0, ipic_type=2, FIFO empty, FSM to IDLE. An outstanding IPIC ack/done arriving after reset is ignored.
- FIFO push on rx_addr_valid. When full, the push is accepted only if a pop occurs in the same cycle; otherwise the address is discarded and ovf_cnt increments. Pop happens on the IDLE->ISSUE transition.
- FSM states: IDLE, ISSUE, WAIT_ACK, WAIT_DONE, CHECK, DELIVER. Word index idx is 0..3.
- IDLE:
  - If FIFO is not empty: pop, latch base, set idx=0, go to ISSUE.
- ISSUE:
  - read_addr = base + PAYLOAD_OFFSET + 4*idx, using ADDR_WIDTH wrap-around arithmetic.
  - Assert ipic_start, go to WAIT_ACK.
- WAIT_ACK:
  - ipic_start stays high until ipic_ack.
  - On ack: ipic_start <= 0, clear timer, go to WAIT_DONE.
- WAIT_DONE:
  - On ipic_done: capture single_read_data into word[idx].
    - If idx==0, go to CHECK.
    - Else if idx<3: idx++, go to ISSUE.
    - Else go to DELIVER.
  - The timer counts every cycle. When it reaches TIMEOUT_CYCLES: timeout_cnt++, discard the frame, go to IDLE.
- CHECK:
  - Flag is word0[5:0]. If flag is 1 or 2: idx=1, go to ISSUE.
  - Otherwise drop_cnt++, go to IDLE. The remaining 3 reads are skipped.
- DELIVER:
  - Wait for consumer_idle. In the cycle it is high:
    - recv_seq=word1, recv_sec=word2, recv_counter2=word3.
    - Pulse recv_ping (flag 1) or recv_ack_ping (flag 2) for exactly 1 cycle, in the cycle after the data registers update.
  - Then go to IDLE.
- Data outputs never change while a pulse is high. recv_ping and recv_ack_ping are never high together.
- Minimum latency, from FIFO non-empty to pulse, with ack and done each arriving 1 cycle after their request: 4×(ISSUE+ACK+DONE) + CHECK + DELIVER + 1.
- Only one IPIC transaction is outstanding at a time. ipic_done seen outside WAIT_DONE is ignored.
- All counters saturate at 16'hFFFF.

Test Plan:
- Push 0x1000_0000, with payload {flag=1, seq=7, sec=0x5A5A0001, cnt2=0x000F4000} and consumer_idle=1 -> 4 reads at 0x10000020/24/28/2C, one recv_ping pulse, recv_seq=7, recv_sec=0x5A5A0001, recv_counter2=0xF4000.
- Flag=2 with consumer_idle held low for 50 cycles -> no pulse while low; recv_ack_ping pulses 2 cycles after consumer_idle rises; data valid during the pulse.
- Flag=0x3F -> exactly 1 read issued, drop_cnt=1, no pulse, FSM back in IDLE.
- 6 back-to-back rx_addr_valid strobes while stalled in WAIT_ACK, FIFO_DEPTH=4 -> ovf_cnt=2 (1 popped + 4 queued), remaining 5 frames delivered in order.
- ipic_done withheld for 1024 cycles after ack -> timeout_cnt=1, no pulse, next queued frame processed normally.
- Assert reset during WAIT_DONE of word 2, then deliver a stale ipic_done -> all outputs 0, ipic_start=0, FIFO empty, stale done ignored, no pulse.
